cnn_layer_accel_job_sequencer: RTL and testbench
================================================

// Module: cnn_layer_accel_job_sequencer
// PURPOSE
//  Host-side controller that runs one cnn_layer_accel_quad job at a time.
//  Sequence: accept a 128-bit job descriptor, start the job, stream one config word per config lane,
//  service the quad's fetch request through an external DMA, then wait for and acknowledge completion.
//  A watchdog aborts any stalled phase and raises a sticky error.
// PARAMETERS
//  C_NUM_CFG_WORDS   4     config words per job; word i goes on config_valid[i] (max 4)
//  C_TIMEOUT_CYCLES  65535 watchdog limit per wait phase; 0 disables the watchdog
//  C_CNT_WIDTH       16    width of job_count and of the watchdog counter
// PORTS
//  clk_if             in   1    interface clock; all logic runs on this clock
//  rst                in   1    asynchronous, active-low reset
//  desc_valid         in   1    job descriptor valid
//  desc_ready         out  1    sequencer ready for a descriptor (IDLE only)
//  desc_data          in   128  job parameters for the quad
//  cfg_in_valid       in   1    config word valid from host
//  cfg_in_ready       out  1    config word consumed
//  cfg_in_data        in   128  config word
//  job_start          out  1    to quad
//  job_accept         in   1    from quad
//  job_parameters     out  128  to quad; latched descriptor
//  config_valid       out  4    to quad; one-hot lane select
//  config_accept      in   4    from quad
//  config_data        out  128  to quad
//  job_fetch_request  in   1    from quad; level, held until acked
//  job_fetch_ack      out  1    to quad; 1-cycle pulse
//  job_fetch_complete out  1    to quad; 1-cycle pulse
//  dma_req            out  1    to DMA; held until dma_ack
//  dma_ack            in   1    DMA accepted request
//  dma_done           in   1    DMA transfer finished (pulse)
//  job_complete       in   1    from quad; level, held until acked
//  job_complete_ack   out  1    to quad; 1-cycle pulse
//  busy               out  1    state != IDLE
//  done_pulse         out  1    1-cycle pulse per successful job
//  job_count          out  C_CNT_WIDTH  successful jobs, wraps to 0
//  err_timeout        out  1    sticky watchdog error
//  err_clear          in   1    clears err_timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0 except desc_ready=1; job_parameters=0; job_count=0; err_timeout=0.
//  IDLE: desc_ready=1.
//    On desc_valid: latch desc_data into job_parameters; go to START next cycle.
//  START: job_start=1 until job_accept is sampled 1.
//    job_start=0 on the following cycle; state -> CONFIG with idx=0.
//  CONFIG:
//    config_valid = cfg_in_valid ? (1<<idx) : 0
//    config_data  = cfg_in_data
//    cfg_in_ready = config_accept[idx]
//    A word transfers when cfg_in_valid && config_accept[idx].
//    After the transfer with idx = C_NUM_CFG_WORDS-1 -> FETCH_WAIT. Otherwise idx++.
//  FETCH_WAIT: on job_fetch_request=1:
//    pulse job_fetch_ack for 1 cycle; assert dma_req; -> DMA_REQ.
//  DMA_REQ: hold dma_req=1 until dma_ack=1; dma_req drops the next cycle; -> DMA_WAIT.
//  DMA_WAIT: on dma_done: pulse job_fetch_complete for 1 cycle; -> RUN.
//    dma_done arriving in the same cycle as dma_ack is honoured: go straight to the job_fetch_complete pulse.
//  RUN: on job_complete: pulse job_complete_ack for 1 cycle and done_pulse for 1 cycle (same cycle);
//    job_count++; -> IDLE.
//  Ignored signals:
//    job_fetch_request outside FETCH_WAIT (quad holds it as a level).
//    job_complete outside RUN.
//    cfg_in_valid outside CONFIG (cfg_in_ready=0).
//  Watchdog:
//    Counter clears on every state change and in IDLE; increments in every other state.
//    At count == C_TIMEOUT_CYCLES: set err_timeout; force all handshake outputs to 0; -> IDLE.
//    job_count is not incremented on a timeout.
//    err_clear=1 clears err_timeout. If a timeout and err_clear occur in the same cycle, set wins.
//    New jobs are accepted even while err_timeout=1.
//  Latency, back-to-back ideal handshakes:
//    desc accept -> job_start: 1 cycle.
//    job_complete sampled -> job_complete_ack: 1 cycle.
//    Next job's desc_ready: 1 cycle after done_pulse.
// TESTING
//  T1 Nominal: desc=128'hA5.., 4 cfg words, immediate accepts.
//    -> job_parameters=desc; config_valid seq 1,2,4,8; one fetch_ack, one fetch_complete,
//       one complete_ack; job_count=1.
//  T2 Backpressure: config_accept[2] low for 10 cycles.
//    -> config_valid=4'b0100 held 10 cycles with data stable; cfg_in_ready=0 throughout; no word lost.
//  T3 Early signals: job_fetch_request=1 during CONFIG.
//    -> no job_fetch_ack until the cycle after the last cfg word; job_complete during DMA_WAIT is ignored.
//  T4 Timeout: C_TIMEOUT_CYCLES=16, dma_done never sent.
//    -> err_timeout=1 at cycle 16 of DMA_WAIT; busy=0; job_count unchanged; err_clear -> 0.
//  T5 Reset mid-job: rst low during RUN.
//    -> all outputs 0, desc_ready=1 immediately (async); next job completes with job_count=1.
//  T6 Wrap: C_CNT_WIDTH=2, 5 jobs back-to-back.
//    -> job_count sequence 1,2,3,0,1; 5 done_pulses.

Source files
------------

// File: rtl/cnn_layer_accel_job_sequencer_if.sv
// Host/quad/DMA handshake bundle for the job sequencer.
// master = sequencer side, slave = host/quad/DMA environment side.
interface cnn_layer_accel_job_sequencer_if #(
    parameter int C_CNT_WIDTH = 16
);
    logic                   desc_valid;
    logic                   desc_ready;
    logic [127:0]           desc_data;
    logic                   cfg_in_valid;
    logic                   cfg_in_ready;
    logic [127:0]           cfg_in_data;
    logic                   job_start;
    logic                   job_accept;
    logic [127:0]           job_parameters;
    logic [3:0]             config_valid;
    logic [3:0]             config_accept;
    logic [127:0]           config_data;
    logic                   job_fetch_request;
    logic                   job_fetch_ack;
    logic                   job_fetch_complete;
    logic                   dma_req;
    logic                   dma_ack;
    logic                   dma_done;
    logic                   job_complete;
    logic                   job_complete_ack;
    logic                   busy;
    logic                   done_pulse;
    logic [C_CNT_WIDTH-1:0] job_count;
    logic                   err_timeout;
    logic                   err_clear;

    modport master (
        input  desc_valid, desc_data, cfg_in_valid, cfg_in_data, job_accept, config_accept,
               job_fetch_request, dma_ack, dma_done, job_complete, err_clear,
        output desc_ready, cfg_in_ready, job_start, job_parameters, config_valid, config_data,
               job_fetch_ack, job_fetch_complete, dma_req, job_complete_ack, busy, done_pulse,
               job_count, err_timeout
    );

    modport slave (
        output desc_valid, desc_data, cfg_in_valid, cfg_in_data, job_accept, config_accept,
               job_fetch_request, dma_ack, dma_done, job_complete, err_clear,
        input  desc_ready, cfg_in_ready, job_start, job_parameters, config_valid, config_data,
               job_fetch_ack, job_fetch_complete, dma_req, job_complete_ack, busy, done_pulse,
               job_count, err_timeout
    );
endinterface

// File: rtl/cnn_layer_accel_job_sequencer.sv
// Runs one quad job at a time: descriptor -> start -> config words -> fetch/DMA -> completion,
// with a per-phase watchdog that aborts to IDLE and raises a sticky error.
module cnn_layer_accel_job_sequencer #(
    parameter int C_NUM_CFG_WORDS  = 4,
    parameter int C_TIMEOUT_CYCLES = 65535,
    parameter int C_CNT_WIDTH      = 16
) (
    input logic                            clk_if,
    input logic                            rst,
    cnn_layer_accel_job_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, START, CONFIG, FETCH_WAIT, DMA_REQ, DMA_WAIT, RUN
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(C_NUM_CFG_WORDS - 1);

    state_t                 state, state_n;
    logic [1:0]             idx, idx_n;
    logic [C_CNT_WIDTH-1:0] wd;
    logic [C_CNT_WIDTH-1:0] job_count;
    logic [127:0]           job_parameters;
    logic                   err_timeout;
    logic                   fetch_ack_q, fetch_cmp_q, cmp_ack_q;
    logic                   fetch_ack_n, fetch_cmp_n, cmp_ack_n;
    logic                   latch, cnt_inc, timeout, desc_ready;

    // Hold off the next descriptor for the done_pulse cycle.
    assign desc_ready = (state == IDLE) && !cmp_ack_q;

    // Watchdog fires on the edge that would take the counter to the limit.
    assign timeout = (C_TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                     (int'(wd) + 1 == C_TIMEOUT_CYCLES);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        fetch_ack_n = 1'b0;
        fetch_cmp_n = 1'b0;
        cmp_ack_n   = 1'b0;
        latch       = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: if (bus.desc_valid && desc_ready) begin
                latch   = 1'b1;
                state_n = START;
            end
            START: if (bus.job_accept) begin
                idx_n   = '0;
                state_n = CONFIG;
            end
            CONFIG: if (bus.cfg_in_valid && bus.config_accept[idx]) begin
                if (idx == LAST_IDX) state_n = FETCH_WAIT;
                else                 idx_n   = idx + 2'd1;
            end
            FETCH_WAIT: if (bus.job_fetch_request) begin
                fetch_ack_n = 1'b1;
                state_n     = DMA_REQ;
            end
            DMA_REQ: if (bus.dma_ack) begin
                if (bus.dma_done) begin
                    fetch_cmp_n = 1'b1;
                    state_n     = RUN;
                end else begin
                    state_n     = DMA_WAIT;
                end
            end
            DMA_WAIT: if (bus.dma_done) begin
                fetch_cmp_n = 1'b1;
                state_n     = RUN;
            end
            RUN: if (bus.job_complete) begin
                cmp_ack_n = 1'b1;
                cnt_inc   = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n     = IDLE;
            fetch_ack_n = 1'b0;
            fetch_cmp_n = 1'b0;
            cmp_ack_n   = 1'b0;
            cnt_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            idx            <= '0;
            wd             <= '0;
            job_count      <= '0;
            job_parameters <= '0;
            err_timeout    <= 1'b0;
            fetch_ack_q    <= 1'b0;
            fetch_cmp_q    <= 1'b0;
            cmp_ack_q      <= 1'b0;
        end else begin
            idx         <= idx_n;
            wd          <= (state_n != state || state == IDLE) ? '0 : wd + 1'b1;
            fetch_ack_q <= fetch_ack_n;
            fetch_cmp_q <= fetch_cmp_n;
            cmp_ack_q   <= cmp_ack_n;
            if (latch)   job_parameters <= bus.desc_data;
            if (cnt_inc) job_count      <= job_count + 1'b1;
            if (timeout)            err_timeout <= 1'b1;
            else if (bus.err_clear) err_timeout <= 1'b0;
        end
    end

    assign bus.desc_ready         = desc_ready;
    assign bus.job_start          = (state == START);
    assign bus.job_parameters     = job_parameters;
    assign bus.config_valid       = (state == CONFIG && bus.cfg_in_valid) ? (4'b0001 << idx) : 4'b0000;
    assign bus.config_data        = (state == CONFIG) ? bus.cfg_in_data : '0;
    assign bus.cfg_in_ready       = (state == CONFIG) && bus.config_accept[idx];
    assign bus.job_fetch_ack      = fetch_ack_q;
    assign bus.dma_req            = (state == DMA_REQ);
    assign bus.job_fetch_complete = fetch_cmp_q;
    assign bus.job_complete_ack   = cmp_ack_q;
    assign bus.done_pulse         = cmp_ack_q;
    assign bus.busy               = (state != IDLE);
    assign bus.job_count          = job_count;
    assign bus.err_timeout        = err_timeout;
endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Directed bench: main instance with a 16-cycle watchdog, plus a 2-bit-counter instance
// driven by an always-ready environment for the job_count wrap sequence.
module tb_cnn_layer_accel_job_sequencer;
    logic clk;
    logic rst;
    logic rst_w;
    int   n_chk;
    int   n_pass;
    int   exp_count;

    cnn_layer_accel_job_sequencer_if #(.C_CNT_WIDTH(16)) b ();
    cnn_layer_accel_job_sequencer_if #(.C_CNT_WIDTH(2))  bw ();

    cnn_layer_accel_job_sequencer #(
        .C_NUM_CFG_WORDS(4), .C_TIMEOUT_CYCLES(16), .C_CNT_WIDTH(16)
    ) dut (.clk_if(clk), .rst(rst), .bus(b.master));

    cnn_layer_accel_job_sequencer #(
        .C_NUM_CFG_WORDS(4), .C_TIMEOUT_CYCLES(65535), .C_CNT_WIDTH(2)
    ) dut_w (.clk_if(clk), .rst(rst_w), .bus(bw.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    endtask

    function automatic logic [127:0] cfg_word(input int i);
        logic [31:0] w;
        w = 32'hC0F1_0000 | 32'(i);
        return {w, ~w, w, 32'h0BAD_F00D};
    endfunction

    task automatic do_start(input logic [127:0] d);
        chk("desc_ready_idle", b.desc_ready, 1);
        b.desc_valid = 1'b1;
        b.desc_data  = d;
        @(negedge clk);
        b.desc_valid = 1'b0;
        b.desc_data  = '0;
        chk("job_start_set", b.job_start, 1);
        chk("job_params", b.job_parameters, d);
        chk("busy_start", b.busy, 1);
        chk("desc_ready_busy", b.desc_ready, 0);
        b.job_accept = 1'b1;
        @(negedge clk);
        b.job_accept = 1'b0;
        chk("job_start_drop", b.job_start, 0);
    endtask

    task automatic do_cfg(input int stall, input bit early);
        logic [3:0] oh;
        for (int i = 0; i < 4; i++) begin
            oh             = 4'b0001 << i;
            b.cfg_in_valid = 1'b1;
            b.cfg_in_data  = cfg_word(i);
            if (i == 2 && stall > 0) begin
                b.config_accept = 4'b1011;
                for (int s = 0; s < stall; s++) begin
                    #1;
                    chk("cfg_stall_valid", b.config_valid, 4'b0100);
                    chk("cfg_stall_ready", b.cfg_in_ready, 0);
                    chk("cfg_stall_data", b.config_data, cfg_word(2));
                    @(negedge clk);
                end
            end
            b.config_accept = 4'hF;
            #1;
            chk("cfg_valid", b.config_valid, oh);
            chk("cfg_ready", b.cfg_in_ready, 1);
            chk("cfg_data", b.config_data, cfg_word(i));
            if (early) chk("early_fetch_no_ack", b.job_fetch_ack, 0);
            @(negedge clk);
        end
        b.cfg_in_valid  = 1'b0;
        b.config_accept = 4'h0;
        #1;
        chk("cfg_valid_done", b.config_valid, 0);
        chk("cfg_ready_done", b.cfg_in_ready, 0);
    endtask

    task automatic do_fetch(input bit same);
        chk("fetch_ack_wait", b.job_fetch_ack, 0);
        chk("dma_req_wait", b.dma_req, 0);
        b.job_fetch_request = 1'b1;
        @(negedge clk);
        chk("fetch_ack_pulse", b.job_fetch_ack, 1);
        chk("dma_req_set", b.dma_req, 1);
        b.job_fetch_request = 1'b0;
        b.dma_ack           = 1'b1;
        b.dma_done          = same;
        @(negedge clk);
        b.dma_ack  = 1'b0;
        b.dma_done = 1'b0;
        chk("dma_req_drop", b.dma_req, 0);
        chk("fetch_ack_single", b.job_fetch_ack, 0);
        chk("fetch_cmp_same", b.job_fetch_complete, same);
    endtask

    task automatic do_dma_done(input bit jc_early);
        if (jc_early) begin
            b.job_complete = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("jc_early_no_ack", b.job_complete_ack, 0);
                chk("jc_early_no_done", b.done_pulse, 0);
            end
            b.job_complete = 1'b0;
        end
        b.dma_done = 1'b1;
        @(negedge clk);
        b.dma_done = 1'b0;
        chk("fetch_cmp_pulse", b.job_fetch_complete, 1);
    endtask

    task automatic do_finish();
        chk("cmp_ack_run", b.job_complete_ack, 0);
        b.job_complete = 1'b1;
        @(negedge clk);
        b.job_complete = 1'b0;
        exp_count++;
        chk("fetch_cmp_single", b.job_fetch_complete, 0);
        chk("cmp_ack_pulse", b.job_complete_ack, 1);
        chk("done_pulse", b.done_pulse, 1);
        chk("job_count", b.job_count, 128'(exp_count));
        chk("busy_done", b.busy, 0);
        chk("desc_ready_hold", b.desc_ready, 0);
        @(negedge clk);
        chk("done_single", b.done_pulse, 0);
        chk("cmp_ack_single", b.job_complete_ack, 0);
        chk("desc_ready_next", b.desc_ready, 1);
    endtask

    initial begin
        int seen;
        int extra;
        n_chk = 0; n_pass = 0; exp_count = 0;
        rst = 1'b0; rst_w = 1'b0;
        b.desc_valid = 0; b.desc_data = '0; b.cfg_in_valid = 0; b.cfg_in_data = '0;
        b.job_accept = 0; b.config_accept = '0; b.job_fetch_request = 0;
        b.dma_ack = 0; b.dma_done = 0; b.job_complete = 0; b.err_clear = 0;
        bw.desc_valid = 0; bw.desc_data = 128'h77; bw.cfg_in_valid = 1; bw.cfg_in_data = '1;
        bw.job_accept = 1; bw.config_accept = 4'hF; bw.job_fetch_request = 1;
        bw.dma_ack = 1; bw.dma_done = 1; bw.job_complete = 1; bw.err_clear = 0;

        @(negedge clk);
        chk("rst_desc_ready", b.desc_ready, 1);
        chk("rst_busy", b.busy, 0);
        chk("rst_job_start", b.job_start, 0);
        chk("rst_params", b.job_parameters, 0);
        chk("rst_count", b.job_count, 0);
        chk("rst_err", b.err_timeout, 0);
        chk("rst_dma_req", b.dma_req, 0);
        chk("rst_cfg_valid", b.config_valid, 0);
        rst = 1'b1;

        // T1 nominal
        do_start({16{8'hA5}});
        do_cfg(0, 0);
        do_fetch(0);
        do_dma_done(0);
        do_finish();

        // T2 backpressure on lane 2, dma_done together with dma_ack
        do_start(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        do_cfg(10, 0);
        do_fetch(1);
        do_finish();

        // T3 early fetch request and early job_complete
        do_start(128'h3);
        b.job_fetch_request = 1'b1;
        do_cfg(0, 1);
        do_fetch(0);
        do_dma_done(1);
        do_finish();

        // T4 dma_done never arrives
        do_start(128'h4);
        do_cfg(0, 0);
        do_fetch(0);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) chk("wd_pre_err", b.err_timeout, 0);
        end
        @(negedge clk);
        chk("wd_err_set", b.err_timeout, 1);
        chk("wd_busy", b.busy, 0);
        chk("wd_count_kept", b.job_count, 128'(exp_count));
        chk("wd_fetch_cmp", b.job_fetch_complete, 0);
        chk("wd_desc_ready", b.desc_ready, 1);

        // New job while err set; stalls in START; timeout beats a concurrent err_clear
        b.desc_valid = 1'b1;
        b.desc_data  = 128'h5;
        @(negedge clk);
        b.desc_valid = 1'b0;
        chk("err_job_start", b.job_start, 1);
        chk("err_still_set", b.err_timeout, 1);
        b.err_clear = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2)  chk("err_cleared", b.err_timeout, 0);
            if (k == 16) chk("start_held", b.job_start, 1);
        end
        @(negedge clk);
        chk("set_wins", b.err_timeout, 1);
        chk("start_wd_start", b.job_start, 0);
        chk("start_wd_busy", b.busy, 0);
        @(negedge clk);
        chk("err_clear_after", b.err_timeout, 0);
        b.err_clear = 1'b0;
        chk("start_wd_count", b.job_count, 128'(exp_count));

        // T5 async reset during RUN
        do_start(128'h6);
        do_cfg(0, 0);
        do_fetch(1);
        #2 rst = 1'b0;
        #1;
        chk("arst_desc_ready", b.desc_ready, 1);
        chk("arst_busy", b.busy, 0);
        chk("arst_params", b.job_parameters, 0);
        chk("arst_count", b.job_count, 0);
        chk("arst_fetch_cmp", b.job_fetch_complete, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
        do_start(128'h7);
        do_cfg(0, 0);
        do_fetch(0);
        do_dma_done(0);
        do_finish();

        // T6 2-bit job_count wrap over 5 back-to-back jobs
        rst_w = 1'b1;
        bw.desc_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 200 && seen < 5; c++) begin
            @(negedge clk);
            if (bw.done_pulse) begin
                seen++;
                chk("wrap_count", bw.job_count, 128'(seen % 4));
                if (seen == 5) bw.desc_valid = 1'b0;
            end
        end
        chk("wrap_jobs_seen", 128'(seen), 128'(5));
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bw.done_pulse) extra++;
        end
        chk("wrap_no_extra", 128'(extra), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
